// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: double-buffered digit store, BCD/hex decode,
// leading-zero suppression and a prescaled anode scan with anti-ghosting blanking.
module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        pre_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] act_value_reg, pend_value_reg;
    logic [NUM_DIGITS-1:0]   act_dp_reg, pend_dp_reg;
    logic                    act_hex_reg, pend_hex_reg;
    logic                    act_lz_reg, pend_lz_reg;
    logic                    pend_flag_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_done_reg;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              cur_nib;
    logic                    cur_sup;
    logic                    cur_dp;
    logic [6:0]              dec;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign tick = enable && (pre_reg == PRE_MAX);
    assign wrap = tick && (idx_reg == IDX_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]    = act_value_reg[gi*4 +: 4];
            assign onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Walk from the most significant digit down; a digit is a leading zero while
    // every nibble from the top down to it is zero. Digit 0 always shows.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (nib[i] == 4'd0);
            suppress[i] = act_lz_reg && zero_run && (i != 0);
        end
    end

    always_comb begin
        cur_nib = 4'd0;
        cur_sup = 1'b0;
        cur_dp  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (onehot[i]) begin
                cur_nib = nib[i];
                cur_sup = suppress[i];
                cur_dp  = act_dp_reg[i];
            end
        end
    end

    always_comb begin
        dec = 7'b0000000;
        case (cur_nib)
            4'h0: dec = 7'b1111110;
            4'h1: dec = 7'b0110000;
            4'h2: dec = 7'b1101101;
            4'h3: dec = 7'b1111001;
            4'h4: dec = 7'b0110011;
            4'h5: dec = 7'b1011011;
            4'h6: dec = 7'b1011111;
            4'h7: dec = 7'b1110000;
            4'h8: dec = 7'b1111111;
            4'h9: dec = 7'b1111011;
            4'hA: dec = 7'b1110111;
            4'hB: dec = 7'b0011111;
            4'hC: dec = 7'b1001110;
            4'hD: dec = 7'b0111101;
            4'hE: dec = 7'b1001111;
            4'hF: dec = 7'b1000111;
            default: dec = 7'b0000000;
        endcase
        if (!act_hex_reg && (cur_nib > 4'd9)) begin
            dec = 7'b0000000;
        end
    end

    always_comb begin
        seg_next = 7'b0000000;
        dp_next  = 1'b0;
        an_next  = '0;
        if (enable) begin
            seg_next = cur_sup ? 7'b0000000 : dec;
            dp_next  = cur_dp;
            an_next  = (pre_reg < BLANK_END) ? '0 : onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_reg        <= '0;
            idx_reg        <= '0;
            act_value_reg  <= '0;
            act_dp_reg     <= '0;
            act_hex_reg    <= 1'b0;
            act_lz_reg     <= 1'b0;
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_hex_reg   <= 1'b0;
            pend_lz_reg    <= 1'b0;
            pend_flag_reg  <= 1'b0;
            seg_reg        <= 7'b0000000;
            dp_reg         <= 1'b0;
            an_reg         <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            if (tick) begin
                pre_reg <= '0;
                idx_reg <= (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            end else if (enable) begin
                pre_reg <= pre_reg + 1'b1;
            end

            frame_done_reg <= wrap;

            // A load landing on the wrap edge bypasses the pending buffer entirely.
            if (wrap && load) begin
                act_value_reg <= value;
                act_dp_reg    <= dp_in;
                act_hex_reg   <= hex_mode;
                act_lz_reg    <= lz_blank;
                pend_flag_reg <= 1'b0;
            end else if (wrap && pend_flag_reg) begin
                act_value_reg <= pend_value_reg;
                act_dp_reg    <= pend_dp_reg;
                act_hex_reg   <= pend_hex_reg;
                act_lz_reg    <= pend_lz_reg;
                pend_flag_reg <= 1'b0;
            end else if (load) begin
                pend_value_reg <= value;
                pend_dp_reg    <= dp_in;
                pend_hex_reg   <= hex_mode;
                pend_lz_reg    <= lz_blank;
                pend_flag_reg  <= 1'b1;
            end

            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    // Registers hold active-high levels, so reset lands on the inactive pin level.
    assign seg        = (ACTIVE_LOW_SEG != 0) ? ~seg_reg : seg_reg;
    assign dp         = (ACTIVE_LOW_SEG != 0) ? ~dp_reg  : dp_reg;
    assign an         = (ACTIVE_LOW_AN  != 0) ? ~an_reg  : an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a reference model pushes the expected pins
// for every clock, and the observed pins are popped and compared just after the edge.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        hex_mode;
    logic        lz_blank;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } obs_t;

    obs_t sb_q[$];
    logic [6:0] seg_tab [16];

    int          m_pre;
    int          m_idx;
    logic [15:0] m_av, m_pv;
    logic [3:0]  m_adp, m_pdp;
    logic        m_ahex, m_alz, m_phex, m_plz, m_flag;

    seven_seg_scanner #(
        .NUM_DIGITS    (4),
        .CLK_DIV       (4),
        .BLANK_CYC     (1),
        .ACTIVE_LOW_SEG(0),
        .ACTIVE_LOW_AN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .hex_mode  (hex_mode),
        .lz_blank  (lz_blank),
        .enable    (enable),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int d);
        logic [3:0] n;
        n = m_av[d*4 +: 4];
        if (m_alz && d != 0 && (m_av >> (4 * d)) == 16'd0) return 7'b0000000;
        if (!m_ahex && n > 4'd9) return 7'b0000000;
        return seg_tab[n];
    endfunction

    task automatic model_reset();
        m_pre = 0; m_idx = 0;
        m_av = '0; m_adp = '0; m_ahex = 1'b0; m_alz = 1'b0;
        m_pv = '0; m_pdp = '0; m_phex = 1'b0; m_plz = 1'b0;
        m_flag = 1'b0;
    endtask

    task automatic model_advance();
        logic wrap;
        wrap = 1'b0;
        if (enable) begin
            if (m_pre == 3) begin
                m_pre = 0;
                wrap  = (m_idx == 3);
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pre++;
            end
        end
        if (wrap && load) begin
            m_av = value; m_adp = dp_in; m_ahex = hex_mode; m_alz = lz_blank;
            m_flag = 1'b0;
        end else if (wrap && m_flag) begin
            m_av = m_pv; m_adp = m_pdp; m_ahex = m_phex; m_alz = m_plz;
            m_flag = 1'b0;
        end else if (load) begin
            m_pv = value; m_pdp = dp_in; m_phex = hex_mode; m_plz = lz_blank;
            m_flag = 1'b1;
        end
    endtask

    task automatic step();
        obs_t e;
        e = '0;
        e.an = 4'b1111;
        if (enable) begin
            e.seg = model_seg(m_idx);
            e.dp  = m_adp[m_idx];
            e.an  = (m_pre < 1) ? 4'b1111 : ~(4'b0001 << m_idx);
            e.fd  = (m_pre == 3 && m_idx == 3);
        end
        sb_q.push_back(e);
        @(posedge clk);
        model_advance();
        #1;
        e = sb_q.pop_front();
        check_eq("seg", 32'(seg), 32'(e.seg));
        check_eq("dp", 32'(dp), 32'(e.dp));
        check_eq("an", 32'(an), 32'(e.an));
        check_eq("frame_done", 32'(frame_done), 32'(e.fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic hx, input logic lz);
        value = v; dp_in = d; hex_mode = hx; lz_blank = lz; load = 1'b1;
        $display("load value=%h dp=%b hex=%0d lz=%0d slot=%0d pre=%0d en=%0d", v, d, hx, lz, m_idx, m_pre, enable);
        step();
        load = 1'b0;
    endtask

    task automatic wait_until(input int pre, input int idx);
        int guard;
        guard = 0;
        while (!(m_pre == pre && m_idx == idx) && guard < 64) begin
            step();
            guard++;
        end
        check_eq("wait_bound", 32'(guard < 64), 32'd1);
    endtask

    task automatic check_reset_pins(input string where);
        check_eq({where, "_seg"}, 32'(seg), 32'h00);
        check_eq({where, "_dp"}, 32'(dp), 32'h0);
        check_eq({where, "_an"}, 32'(an), 32'hF);
        check_eq({where, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000; seg_tab[2]  = 7'b1101101;
        seg_tab[3]  = 7'b1111001; seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
        seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000; seg_tab[8]  = 7'b1111111;
        seg_tab[9]  = 7'b1111011; seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b0011111;
        seg_tab[12] = 7'b1001110; seg_tab[13] = 7'b0111101; seg_tab[14] = 7'b1001111;
        seg_tab[15] = 7'b1000111;

        rst = 1'b1; value = '0; dp_in = '0; load = 1'b0;
        hex_mode = 1'b0; lz_blank = 1'b0; enable = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_pins("reset");
        rst = 1'b0;
        $display("reset released");
        run(40);

        // Hex decode; the old content must persist until the wrap.
        do_load(16'h12AF, 4'b0000, 1'b1, 1'b0);
        run(40);

        // BCD blanks A, then all-zero with suppression.
        do_load(16'h00A5, 4'b0000, 1'b0, 1'b0);
        run(36);
        do_load(16'h0000, 4'b0000, 1'b0, 1'b1);
        run(36);

        // Interior zero kept, decimal point on digit 1 only.
        do_load(16'h0305, 4'b0010, 1'b0, 1'b1);
        run(36);

        // Last load wins, then a load exactly on the wrap edge.
        do_load(16'h1111, 4'b0000, 1'b1, 1'b0);
        run(3);
        do_load(16'h2222, 4'b0000, 1'b1, 1'b0);
        run(36);
        wait_until(3, 3);
        do_load(16'h3333, 4'b0001, 1'b1, 1'b0);
        run(20);

        // Freeze mid-slot, accept a load while frozen, then resume.
        wait_until(2, 1);
        enable = 1'b0;
        $display("enable dropped at slot=%0d pre=%0d", m_idx, m_pre);
        run(3);
        do_load(16'hBEEF, 4'b1000, 1'b1, 1'b0);
        run(3);
        enable = 1'b1;
        $display("enable restored");
        run(40);

        // Asynchronous reset mid-frame discards pending data.
        do_load(16'h4444, 4'b1111, 1'b1, 1'b0);
        run(3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_pins("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_pins("held_reset");
        model_reset();
        rst = 1'b0;
        $display("reset released after mid-frame reset");
        run(40);

        check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised multi-digit, time-multiplexed seven-segment display driver.
- Decodes each 4-bit nibble of a packed input word in either BCD or full-hex mode, with optional leading-zero suppression and per-digit decimal points.
- Scans the digits one at a time via anode enables, using a programmable refresh prescaler.
- Sits between the datapath (which presents `value` and pulses `load`) and the board-level segment/anode pins; double-buffered so the display never tears mid-frame.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, 1..8.
- CLK_DIV, 50000: clock cycles per digit slot, >= 2.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes inactive (anti-ghosting), 0 <= BLANK_CYC < CLK_DIV.
- ACTIVE_LOW_SEG, 0: 1 inverts `seg` and `dp` at the output.
- ACTIVE_LOW_AN, 1: 1 inverts `an` at the output.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- value, input, 4*NUM_DIGITS: packed digits; nibble 0 (bits 3:0) is the rightmost digit.
- dp_in, input, NUM_DIGITS: decimal-point request per digit.
- load, input, 1: single-cycle strobe that captures `value`/`dp_in`.
- hex_mode, input, 1: 1 selects hex (0-F); 0 selects BCD (0-9, nibbles 10-15 blank).
- lz_blank, input, 1: 1 enables leading-zero suppression.
- enable, input, 1: 0 freezes the scan and blanks the display.
- seg, output, 7: segments {a,b,c,d,e,f,g}, bit 6 = a.
- dp, output, 1: decimal-point segment.
- an, output, NUM_DIGITS: one-hot anode enables.
- frame_done, output, 1: one-cycle pulse at each frame wrap.

Behaviour:
- Reset, asynchronous: prescaler=0, idx=0, active buffer=0, pending buffer=0, pending flag=0. All outputs drive their inactive level (seg/dp off, an all off after polarity), frame_done=0.
- Prescaler: counts 0..CLK_DIV-1 while `enable`=1. A tick occurs when the prescaler equals CLK_DIV-1; at the tick the prescaler wraps to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
- Frame wrap: the tick where idx goes NUM_DIGITS-1 -> 0. `frame_done` is high the cycle after this edge, for exactly 1 cycle. On the same edge, if the pending flag is set, pending is copied to active and the flag is cleared.
- Load: `load`=1 captures `value`/`dp_in`/`hex_mode`/`lz_blank` into pending and sets the flag. A second load before the wrap overwrites the first (last wins).
- Load on the same cycle as a wrap edge: the loaded data goes directly to active and the flag ends clear.
- Decode table, active-high pre-polarity:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- BCD mode: nibbles 10-15 decode to 0000000.
- Leading-zero suppression: a digit is blanked (seg=0, dp still honoured) if its nibble is 0 and every more-significant nibble is 0. Digit 0 is never suppressed, so all-zero shows a single "0".
- Output registration: seg/dp/an are registered, reflecting idx and prescaler with exactly 1 cycle latency. `an` is one-hot on idx, except all inactive while prescaler < BLANK_CYC.
- `enable`=0: prescaler and idx hold; from the next cycle an is all inactive and seg/dp are off. Loads are still accepted, and a pending update waits for the next wrap. On re-enable, scanning resumes from the held state.
- Polarity inversion is applied after the output registers' logic, so the inactive level follows the ACTIVE_LOW_* parameters.
- Reset mid-frame: immediate return to the reset state and pending data is discarded. After release the scan starts at digit 0 with a full slot.
- Implementation size: roughly 150-250 lines.

Test Plan:
1. Reset release, NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1, ACTIVE_LOW_AN=1:
   - Digits advance every 4 cycles (idx 0,1,2,3,0).
   - an=1110 in slot 0 except 1111 during its first cycle.
   - frame_done pulses once every 16 cycles.
2. load value=16'h12AF, hex_mode=1:
   - After the next frame wrap, the digit-0 slot shows 1000111 (F), digit 1 shows 1110111, digit 2 shows 1101101, digit 3 shows 0110000.
   - Before the wrap, the previous content is still shown.
3. value=16'h00A5, hex_mode=0:
   - Digit 1 (A) is blank and digit 0 shows 1011011.
   - With lz_blank=1 and value=16'h0000: only digit 0 shows 1111110, digits 1-3 are 0000000.
4. lz_blank=1, value=16'h0305:
   - Digit 3 is blank, digit 2 shows 1111001, digit 1 shows 1111110 (interior zero kept), digit 0 shows 1011011.
   - dp_in=4'b0010 lights dp only in the digit-1 slot.
5. Two loads (16'h1111, then 16'h2222) within one frame:
   - Only 2222 is displayed after the wrap.
   - A load coincident with the wrap edge shows its value in the very next frame.
6. enable=0 mid-slot:
   - The next cycle has an all inactive; prescaler and idx hold.
   - Re-enable continues the same slot.
   - rst asserted mid-frame forces outputs inactive on the same cycle, asynchronously, and the pending data is lost.
